instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch front-end: reader side of the PC. Tracks the fetch PC and issues word reads to instruction memory
//  over a valid/ready request bus with variable response latency. Buffers returned words in a 2-entry FIFO
//  and presents {instruction, pc} to decode through a valid/ready handshake. Sits between the PC/next-PC logic and decode.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch address loaded on reset
//  BUF_DEPTH   2              output FIFO entries; power of two, >=2
// PORTS
//  clk             in   1   rising-edge clock
//  reset           in   1   synchronous, active-high
//  redirect_valid  in   1   branch/jump/trap redirect, single-cycle pulse
//  redirect_pc     in   32  new fetch address
//  imem_req_valid  out  1   read request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  word address (bits[1:0] always 0)
//  imem_rsp_valid  in   1   read data valid; exactly one per accepted request; >=1 cycle after acceptance
//  imem_rsp_data   in   32  read data
//  inst_valid      out  1   FIFO head valid
//  inst_ready      in   1   decode consumes head
//  inst_data       out  32  instruction at head
//  inst_pc         out  32  PC of inst_data
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high.
//  - Reset:
//    - State = IDLE; fetch_pc = RESET_PC; FIFO emptied; drop flag cleared.
//    - imem_req_valid = 0, inst_valid = 0, inst_data = 0, inst_pc = 0.
//  - FSM:
//    - IDLE -> REQ on the first cycle after reset deasserts.
//    - REQ: imem_req_valid = 1 only when (FIFO occupancy + outstanding) < BUF_DEPTH; imem_req_addr = fetch_pc.
//      On valid & ready: record req_pc = fetch_pc, fetch_pc += 4 (wraps mod 2^32), go to WAIT.
//    - WAIT: on imem_rsp_valid, push {imem_rsp_data, req_pc} to FIFO unless drop = 1; clear drop; return to REQ.
//  - At most one request outstanding. Request-to-inst_valid latency is memory latency + 1 (FIFO output registered).
//  - Request stability: once imem_req_valid is high, addr holds until accepted, except on redirect.
//  - Redirect, any state except IDLE:
//    - FIFO flushed; inst_valid = 0 next cycle.
//    - fetch_pc = {redirect_pc[31:2], 2'b00}.
//    - In WAIT: drop = 1, so the in-flight response is discarded, then new fetch.
//    - In REQ: an un-accepted request is withdrawn next cycle.
//    - Redirect in the same cycle as request acceptance: that request counts as outstanding and its response is dropped.
//    - Redirect wins over a same-cycle inst_ready pop and over a same-cycle response push.
//  - FIFO:
//    - Simultaneous push and pop when full is legal; occupancy is unchanged.
//    - Push when full never happens (guarded by the REQ credit rule).
//    - Pop when empty is ignored.
//    - Head stays stable while inst_valid & !inst_ready.
//  - Reset mid-operation: everything returns to reset values; a response arriving during or after reset is ignored.
// CONFIGURATION
//  IF_MISALIGN_CHK_EN defined:
//    - Adds output port inst_misalign (1 bit).
//    - A redirect with redirect_pc[1:0] != 0 does not fetch. It pushes one FIFO entry {32'h0000_0013, redirect_pc}
//      with inst_misalign = 1, then stalls in REQ with imem_req_valid = 0 until the next redirect.
//    - inst_misalign = 0 for normal entries.
//  IF_MISALIGN_CHK_EN undefined:
//    - No extra port; redirect_pc[1:0] are silently cleared.
// TESTING
//  1. Reset, memory ready = 1, 1-cycle latency, inst_ready = 1
//     -> addrs 0x0, 0x4, 0x8 issued in order; inst_pc = 0x0, 0x4, 0x8 with matching data.
//  2. inst_ready = 0 for 10 cycles
//     -> exactly 2 entries buffered (0x0, 0x4), imem_req_valid = 0, head stable;
//        release -> 0x8 fetched next.
//  3. Redirect to 0x100 while in WAIT on 0x8
//     -> 0x8 response dropped; next inst_pc = 0x100, then 0x104.
//  4. imem_req_ready = 0 for 5 cycles
//     -> imem_req_addr held constant; redirect to 0x40 in cycle 3 -> addr becomes 0x40.
//  5. fetch_pc reaches 0xFFFF_FFFC
//     -> next addr 0x0000_0000; inst_pc sequence FFFF_FFFC, 0000_0000.
//  6. Reset asserted mid-WAIT with response landing during reset
//     -> no inst_valid; first request after release is RESET_PC.
//     With IF_MISALIGN_CHK_EN, redirect to 0x102 -> inst_misalign = 1, inst_pc = 0x102, no memory request.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch front-end: fetch PC, single-outstanding imem read port, output FIFO to decode.
// Optional IF_MISALIGN_CHK_EN: a misaligned redirect emits one flagged NOP entry and stalls fetch.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic        inst_misalign
`endif
);
    localparam int unsigned    PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [31:0]      req_pc;
    logic             drop;
    logic             stalled;
    logic [31:0]      buf_data [BUF_DEPTH];
    logic [31:0]      buf_pc   [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             redir;
    logic             req_fire;
    logic             push;
    logic             pop;

`ifdef IF_MISALIGN_CHK_EN
    logic stall;
    logic bad_redirect;
    logic buf_mis [BUF_DEPTH];

    assign stalled       = stall;
    assign bad_redirect  = redir && (redirect_pc[1:0] != 2'b00);
    assign inst_misalign = inst_valid ? buf_mis[rd_ptr] : 1'b0;
`else
    assign stalled = 1'b0;
`endif

    // Only one request is ever outstanding and REQ implies none is, so occupancy alone is the credit.
    assign redir          = redirect_valid && (state != S_IDLE);
    assign imem_req_valid = (state == S_REQ) && !stalled && (count < DEPTH);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign inst_valid     = (count != '0);
    assign push           = (state == S_WAIT) && imem_rsp_valid && !drop && !redir;
    assign pop            = inst_valid && inst_ready && !redir;
    assign inst_data      = inst_valid ? buf_data[rd_ptr] : '0;
    assign inst_pc        = inst_valid ? buf_pc[rd_ptr]   : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            drop     <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
`ifdef IF_MISALIGN_CHK_EN
            stall    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (req_fire) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        drop  <= 1'b0;
                        state <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (push) begin
                buf_data[wr_ptr] <= imem_rsp_data;
                buf_pc[wr_ptr]   <= req_pc;
`ifdef IF_MISALIGN_CHK_EN
                buf_mis[wr_ptr]  <= 1'b0;
`endif
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;

            // Redirect overrides the pointer/PC updates above; a request in flight (or accepted now) is dropped.
            if (redir) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                if (((state == S_WAIT) && !imem_rsp_valid) || req_fire)
                    drop <= 1'b1;
`ifdef IF_MISALIGN_CHK_EN
                stall <= 1'b0;
                if (bad_redirect) begin
                    buf_data[0] <= 32'h0000_0013;
                    buf_pc[0]   <= redirect_pc;
                    buf_mis[0]  <= 1'b1;
                    wr_ptr      <= PTR_W'(1);
                    count       <= (PTR_W + 1)'(1);
                    stall       <= 1'b1;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: behavioural variable-latency imem plus immediate-assertion checks.
module tb_instr_fetch;
    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef IF_MISALIGN_CHK_EN
    logic        inst_misalign;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned mem_lat = 1;
    logic [31:0] acc_q[$];

    instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef IF_MISALIGN_CHK_EN
        , .inst_misalign(inst_misalign)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Memory: samples acceptance at the edge, answers mem_lat edges later with data = ~addr.
    initial begin : mem_model
        bit          busy;
        bit          acc;
        int unsigned pend;
        logic [31:0] a;
        logic [31:0] paddr;
        busy = 0;
        pend = 0;
        paddr = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            acc = imem_req_valid && imem_req_ready && !reset;
            a   = imem_req_addr;
            #1;
            imem_rsp_valid = 1'b0;
            if (acc) begin
                busy  = 1;
                pend  = mem_lat;
                paddr = a;
                acc_q.push_back(a);
            end
            if (busy) begin
                pend--;
                if (pend == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = ~paddr;
                    busy = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        repeat (6) step();
        acc_q.delete();
        reset = 1'b0;
        step();
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_acc(input string tag, input int unsigned n);
        for (int i = 0; i < 60 && acc_q.size() < n; i++) step();
        chk({tag, "_acc_count"}, 32'(acc_q.size() >= n), 32'd1);
    endtask

    task automatic wait_inst(input string tag, input logic [31:0] pc, input logic [31:0] data);
        for (int i = 0; i < 40 && inst_valid !== 1'b1; i++) step();
        chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
        chk({tag, "_pc"}, inst_pc, pc);
        chk({tag, "_data"}, inst_data, data);
`ifdef IF_MISALIGN_CHK_EN
        chk({tag, "_misalign"}, 32'(inst_misalign), 32'd0);
`endif
        step();
    endtask

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        mem_lat = 1;

        // 1: reset values, then sequential fetch
        repeat (6) step();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        acc_q.delete();
        reset = 1'b0;
        step();
        chk("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_first_addr", imem_req_addr, 32'h0);
        wait_inst("t1_i0", 32'h0, 32'hFFFF_FFFF);
        wait_inst("t1_i1", 32'h4, 32'hFFFF_FFFB);
        wait_inst("t1_i2", 32'h8, 32'hFFFF_FFF7);
        wait_acc("t1", 3);
        chk("t1_acc0", acc_q[0], 32'h0);
        chk("t1_acc1", acc_q[1], 32'h4);
        chk("t1_acc2", acc_q[2], 32'h8);

        // 2: decode backpressure fills the buffer and stops requests
        inst_ready = 1'b0;
        do_reset();
        repeat (10) step();
        chk("t2_full_valid", 32'(inst_valid), 32'd1);
        chk("t2_head_pc", inst_pc, 32'h0);
        chk("t2_head_data", inst_data, 32'hFFFF_FFFF);
        chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_acc_count", 32'(acc_q.size()), 32'd2);
        repeat (3) step();
        chk("t2_head_pc_stable", inst_pc, 32'h0);
        chk("t2_req_valid_stable", 32'(imem_req_valid), 32'd0);
        inst_ready = 1'b1;
        wait_inst("t2_i0", 32'h0, 32'hFFFF_FFFF);
        wait_inst("t2_i1", 32'h4, 32'hFFFF_FFFB);
        wait_inst("t2_i2", 32'h8, 32'hFFFF_FFF7);

        // 3: redirect while waiting on 0x8 drops its response
        mem_lat = 3;
        do_reset();
        wait_inst("t3_i0", 32'h0, 32'hFFFF_FFFF);
        wait_inst("t3_i1", 32'h4, 32'hFFFF_FFFB);
        wait_acc("t3_wait8", 3);
        chk("t3_acc2", acc_q[2], 32'h8);
        pulse_redirect(32'h0000_0100);
        wait_inst("t3_r0", 32'h100, 32'hFFFF_FEFF);
        wait_inst("t3_r1", 32'h104, 32'hFFFF_FEFB);

        // 4: memory stall holds address; redirect replaces it
        mem_lat = 1;
        imem_req_ready = 1'b0;
        do_reset();
        chk("t4_c1_addr", imem_req_addr, 32'h0);
        step();
        chk("t4_c2_addr", imem_req_addr, 32'h0);
        chk("t4_c2_valid", 32'(imem_req_valid), 32'd1);
        step();
        pulse_redirect(32'h0000_0040);
        chk("t4_c4_addr", imem_req_addr, 32'h40);
        chk("t4_c4_valid", 32'(imem_req_valid), 32'd1);
        step();
        chk("t4_c5_addr", imem_req_addr, 32'h40);
        imem_req_ready = 1'b1;
        wait_acc("t4", 1);
        chk("t4_acc0", acc_q[0], 32'h40);
        wait_inst("t4_i0", 32'h40, 32'hFFFF_FFBF);

        // 5: redirect on the accepting cycle, then PC wrap
        do_reset();
        pulse_redirect(32'hFFFF_FFFC);
        wait_inst("t5_i0", 32'hFFFF_FFFC, 32'h0000_0003);
        wait_inst("t5_i1", 32'h0, 32'hFFFF_FFFF);
        wait_acc("t5", 3);
        chk("t5_acc0_dropped", acc_q[0], 32'h0);
        chk("t5_acc1", acc_q[1], 32'hFFFF_FFFC);
        chk("t5_acc2_wrap", acc_q[2], 32'h0);

        // 6: reset mid-WAIT with the response landing during reset
        mem_lat = 4;
        do_reset();
        wait_acc("t6", 1);
        reset = 1'b1;
        step();
        chk("t6_rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        repeat (4) step();
        chk("t6_rst_inst_valid_late", 32'(inst_valid), 32'd0);
        acc_q.delete();
        reset = 1'b0;
        step();
        chk("t6_post_inst_valid", 32'(inst_valid), 32'd0);
        chk("t6_post_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_post_addr", imem_req_addr, 32'h0);
        wait_acc("t6_post", 1);
        chk("t6_acc0", acc_q[0], 32'h0);
        wait_inst("t6_i0", 32'h0, 32'hFFFF_FFFF);

        // 7: misaligned redirect
        mem_lat = 1;
`ifdef IF_MISALIGN_CHK_EN
        imem_req_ready = 1'b0;
        inst_ready = 1'b0;
        do_reset();
        pulse_redirect(32'h0000_0102);
        chk("t7_mis_valid", 32'(inst_valid), 32'd1);
        chk("t7_mis_flag", 32'(inst_misalign), 32'd1);
        chk("t7_mis_pc", inst_pc, 32'h102);
        chk("t7_mis_data", inst_data, 32'h0000_0013);
        chk("t7_mis_req_valid", 32'(imem_req_valid), 32'd0);
        imem_req_ready = 1'b1;
        repeat (5) step();
        chk("t7_stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t7_stall_acc", 32'(acc_q.size()), 32'd0);
        chk("t7_stall_head_pc", inst_pc, 32'h102);
        inst_ready = 1'b1;
        pulse_redirect(32'h0000_0200);
        wait_acc("t7", 1);
        chk("t7_acc0", acc_q[0], 32'h200);
        wait_inst("t7_i0", 32'h200, 32'hFFFF_FDFF);
`else
        do_reset();
        pulse_redirect(32'h0000_0203);
        wait_inst("t7_i0", 32'h200, 32'hFFFF_FDFF);
        wait_acc("t7", 2);
        chk("t7_acc1_aligned", acc_q[1], 32'h200);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
